// File: rtl/pwd_lock_pkg.sv
// Shared types and constants for the password-lock controller.
package pwd_lock_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StUnlocked = 2'b01,
    StAlarm    = 2'b10,
    StSet      = 2'b11
  } state_e;

  localparam int unsigned DIGIT_W     = 4;
  localparam logic [3:0]  BLANK_DIGIT = 4'hF;
  localparam int unsigned TIMER_W     = 32;

endpackage

// File: rtl/lock_timer.sv
// Loadable 32-bit down-counter; done is a registered flag that is high while the count is zero.
module lock_timer
  import pwd_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               enable,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      done    <= 1'b1;
    end else if (load) begin
      count_q <= value;
      done    <= (value == '0);
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
      done    <= (count_q == TIMER_W'(1));
    end
  end

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Password-lock controller: digit entry, compare, fail counting, timed unlock and alarm lockout.
// Password change mode (SET state) is built only when PWD_LOCK_CHANGE_PW_EN is defined.
module pwd_lock_ctrl
  import pwd_lock_pkg::*;
#(
  parameter int unsigned         PW_LEN         = 4,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 16'h1234,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter logic [31:0]         UNLOCK_CYCLES  = 32'd500_000_000,
  parameter logic [31:0]         LOCKOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  digit_in,
  input  logic                        digit_pulse,
  input  logic                        confirm_pulse,
  input  logic                        clear_pulse,
  input  logic                        set_pulse,
  output logic                        unlock,
  output logic                        alarm,
  output logic [$clog2(PW_LEN+1)-1:0] entry_cnt,
  output logic [4*PW_LEN-1:0]         entry_buf,
  output logic [3:0]                  fail_cnt,
  output logic [1:0]                  state_code
);

  localparam int unsigned CNT_W = $clog2(PW_LEN+1);
  localparam int unsigned BUF_W = DIGIT_W * PW_LEN;
  localparam logic [3:0]  MAX_T = 4'(MAX_TRIES);
  localparam logic [BUF_W-1:0] BLANK_BUF = {PW_LEN{BLANK_DIGIT}};

`ifdef PWD_LOCK_CHANGE_PW_EN
  localparam bit ChangeEn = 1'b1;
`else
  localparam bit ChangeEn = 1'b0;
`endif

  state_e             state_q;
  logic [BUF_W-1:0]   pw_q;
  logic               clr_p, cfm_p, set_p, dig_p;
  logic               entry_full, match, digit_ok;
  logic [BUF_W-1:0]   buf_shift;
  int unsigned        slot;
  logic [3:0]         fail_inc;
  logic               tmr_load, tmr_en, tmr_done;
  logic [TIMER_W-1:0] tmr_value;

  assign state_code = state_q;

  always_comb begin
    // Only the highest-priority pulse of a cycle survives.
    clr_p = clear_pulse;
    cfm_p = confirm_pulse & ~clear_pulse;
    set_p = ChangeEn & set_pulse & ~clear_pulse & ~confirm_pulse;
    dig_p = digit_pulse & ~clear_pulse & ~confirm_pulse & ~set_p;

    entry_full = (entry_cnt == CNT_W'(PW_LEN));
    match      = entry_full && (entry_buf == pw_q);
    digit_ok   = dig_p && (digit_in <= 4'd9) && !entry_full;

    buf_shift = entry_buf;
    slot      = PW_LEN - 32'(entry_cnt) - 1;
    if (!entry_full) begin
      buf_shift[DIGIT_W*slot +: DIGIT_W] = digit_in;
    end

    fail_inc = (fail_cnt >= MAX_T) ? MAX_T : fail_cnt + 4'd1;

    tmr_load  = 1'b0;
    tmr_value = '0;
    if ((state_q == StIdle) && cfm_p) begin
      if (match) begin
        tmr_load  = 1'b1;
        tmr_value = UNLOCK_CYCLES - 32'd1;
      end else if (fail_inc == MAX_T) begin
        tmr_load  = 1'b1;
        tmr_value = LOCKOUT_CYCLES - 32'd1;
      end
    end
    // SET leaves the timer frozen.
    tmr_en = (state_q == StUnlocked) || (state_q == StAlarm);
  end

  lock_timer u_lock_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .enable (tmr_en),
    .done   (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      entry_cnt <= '0;
      entry_buf <= BLANK_BUF;
      fail_cnt  <= '0;
      pw_q      <= DEFAULT_PW;
    end else begin
      case (state_q)
        StIdle: begin
          if (clr_p) begin
            entry_cnt <= '0;
            entry_buf <= BLANK_BUF;
          end else if (cfm_p) begin
            entry_cnt <= '0;
            entry_buf <= BLANK_BUF;
            if (match) begin
              state_q  <= StUnlocked;
              unlock   <= 1'b1;
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_inc;
              if (fail_inc == MAX_T) begin
                state_q <= StAlarm;
                alarm   <= 1'b1;
              end
            end
          end else if (digit_ok) begin
            entry_buf <= buf_shift;
            entry_cnt <= entry_cnt + CNT_W'(1);
          end
        end
        StUnlocked: begin
          if (clr_p || tmr_done) begin
            state_q <= StIdle;
            unlock  <= 1'b0;
          end else if (set_p) begin
            state_q   <= StSet;
            entry_cnt <= '0;
            entry_buf <= BLANK_BUF;
          end
        end
        StAlarm: begin
          if (tmr_done) begin
            state_q  <= StIdle;
            alarm    <= 1'b0;
            fail_cnt <= '0;
          end
        end
        StSet: begin
          if (clr_p || cfm_p) begin
            if (cfm_p && entry_full) begin
              pw_q <= entry_buf;
            end
            state_q   <= StIdle;
            unlock    <= 1'b0;
            entry_cnt <= '0;
            entry_buf <= BLANK_BUF;
          end else if (digit_ok) begin
            entry_buf <= buf_shift;
            entry_cnt <= entry_cnt + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
